stack_arbiter: RTL and testbench
================================

Name: stack_arbiter

Overview:
- Shares one 16-bit LIFO stack block between NREQ requesters, for example the call/return unit and the interrupt save/restore unit.
- Accepts push/pop requests over a valid/ready handshake and arbitrates round-robin, issuing at most one stack operation per cycle.
- Routes pop data back to the requester that issued the pop, tagged with its ID.
- Also sequences a stack flush.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DEPTH, 16, stack depth; must equal the depth of the attached LIFO.
- DW, 16, data width.
- IDW, 1, requester ID width, ceil(log2(NREQ)) with a minimum of 1.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_op  in  NREQ  per-requester op: 0 = push, 1 = pop.
- req_data  in  NREQ*DW  per-requester push data; requester i uses bits [i*DW +: DW].
- req_ready  out  NREQ  one-hot grant; the handshake completes when valid and ready are both high.
- resp_valid  out  1  pop response valid, single-cycle pulse.
- resp_id  out  IDW  requester that issued the answered pop.
- resp_data  out  DW  popped value.
- resp_err  out  1  pop was issued against an empty stack.
- flush  in  1  request to empty the stack.
- flush_done  out  1  one-cycle pulse when the flush completes.
- lifo_reset  out  1  drives the LIFO's reset input.
- lifo_push, lifo_pop  out  1 each  LIFO controls.
- lifo_data  out  DW  LIFO write data.
- lifo_q  in  DW  LIFO read data.
- lifo_empty, lifo_full  in  1 each  LIFO status flags, registered inside the LIFO.

Behaviour:

Reset:
- While reset is high: req_ready=0, resp_valid=0, resp_err=0, resp_id=0, resp_data=0, flush_done=0, lifo_push=0, lifo_pop=0, lifo_data=0, lifo_reset=1.
- Round-robin pointer returns to requester 0.
- Any in-flight pop response is dropped.
- FSM returns to RUN.

FSM states:
- RUN: normal arbitration.
- FLUSH: lifo_reset=1 for exactly one cycle; no grants.
- DRAIN: one cycle; no grants; lets the LIFO flags settle; flush_done=1.
- Transitions:
  - RUN -> FLUSH when flush=1. Flush has priority over all requests that cycle, so no grant is issued.
  - FLUSH -> DRAIN unconditionally.
  - DRAIN -> RUN unconditionally.
- A pop issued in the cycle before flush still returns its response.

Eligibility and grant:
- A push from requester i is eligible iff !lifo_full and the previous cycle was not a push.
  - The LIFO full flag lags a push by one cycle, so back-to-back pushes are not allowed.
- A pop is always eligible.
- Round-robin grant: search starts at the requester after the last grantee.
- req_ready is combinational from req_valid, req_op, the flags and the FSM state; it is asserted for at most one requester.

Issue:
- Granted push: lifo_push=1, lifo_data=req_data[i] in the grant cycle.
- Granted pop with !lifo_empty:
  - lifo_pop=1 in the grant cycle.
  - Next cycle: resp_valid=1, resp_id=i, resp_data=lifo_q, resp_err=0.
- Granted pop with lifo_empty:
  - No lifo_pop.
  - Next cycle: resp_valid=1, resp_err=1, resp_data=0.

Pop timing and throughput:
- A pop immediately following a grant (push or pop) in the previous cycle uses the flags as they stand at the grant edge.
- The requester must ignore resp_err when the pop follows its own push; the bench checks the data value only.
- Back-to-back pops are allowed; throughput is 1 pop per cycle, 1 push per 2 cycles.

Optional Feature:
- Macro: STACK_ARBITER_OCCUPANCY_EN.
- When defined:
  - Adds outputs occupancy[log2(DEPTH+1)-1:0] and high_water[log2(DEPTH+1)-1:0].
  - occupancy is a shadow counter: +1 on lifo_push, -1 on lifo_pop, cleared by reset or the FLUSH state.
  - high_water is the maximum occupancy seen; cleared only by reset.
  - Push eligibility uses occupancy<DEPTH instead of lifo_full, which enables back-to-back pushes (throughput 1 op/cycle).
- When undefined: neither port exists, and eligibility uses the LIFO flags as described above.

Decomposition:
- Package stack_arbiter_pkg holds:
  - OP_PUSH=1'b0 and OP_POP=1'b1.
  - FSM state encoding RUN/FLUSH/DRAIN.
  - Default DW=16 and DEPTH=16.
- Sub-module rr_arbiter: NREQ-wide round-robin grant.
  - Inputs: eligible vector, advance strobe.
  - Output: one-hot grant.
  - Instantiated once.

Test Plan:
1. Reset held 3 cycles → lifo_reset=1 throughout, req_ready=0, resp_valid=0. After reset: req 0 pushes 0x1234, idle 1 cycle, req 1 pops → req 1 gets resp_valid, resp_id=1, resp_data=0x1234, resp_err=0.
2. Both requesters hold pop continuously on an empty stack → grants alternate 0,1,0,1; each response has resp_err=1, resp_data=0; lifo_pop never asserted.
3. 16 pushes of 0x0000..0x000F (spaced by 1 idle cycle), then a 17th push → 17th req_ready stays 0 while lifo_full=1. Then 16 pops → data 0x000F down to 0x0000, in order.
4. Push 0xAAAA, push 0xBBBB, then flush → lifo_reset for 1 cycle, flush_done pulse 2 cycles after flush; a following pop gives resp_err=1.
5. Pop granted in the cycle before flush → response still delivered with correct data; flush completes normally.
6. With STACK_ARBITER_OCCUPANCY_EN defined: 5 back-to-back pushes, then 2 pops → occupancy=3, high_water=5; after flush → occupancy=0, high_water=5.

Source files
------------

// File: rtl/stack_arbiter_pkg.sv
// stack_arbiter_pkg -- shared definitions for the stack arbiter slice.
//   OP_PUSH / OP_POP : request opcode encoding on req_op
//   state_t          : flush sequencer states (RUN, FLUSH, DRAIN)
//   DEF_DW/DEF_DEPTH : default data width and attached LIFO depth
package stack_arbiter_pkg;

   localparam logic OP_PUSH   = 1'b0;
   localparam logic OP_POP    = 1'b1;
   localparam int   DEF_DW    = 16;
   localparam int   DEF_DEPTH = 16;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/stack_arbiter_if.sv
// stack_arbiter_if -- requester-side bundle of the stack arbiter.
//   req_valid/req_op/req_data : per-requester request (op 0 = push, 1 = pop);
//                               requester i owns req_data[i*DW +: DW]
//   req_ready                 : one-hot grant back to the requesters
//   resp_valid/id/data/err    : single-cycle pop response
// Modports: master = requester side, slave = arbiter side.
interface stack_arbiter_if
   import stack_arbiter_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int DW   = DEF_DW,
   parameter int IDW  = 1
);

   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_op;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               resp_valid;
   logic [IDW-1:0]     resp_id;
   logic [DW-1:0]      resp_data;
   logic               resp_err;

   modport master (
      output req_valid, req_op, req_data,
      input  req_ready, resp_valid, resp_id, resp_data, resp_err
   );

   modport slave (
      input  req_valid, req_op, req_data,
      output req_ready, resp_valid, resp_id, resp_data, resp_err
   );

endinterface

// File: rtl/stack_arbiter_rr_arbiter.sv
// rr_arbiter -- NREQ-wide round-robin grant.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   eligible     : requesters that may be granted this cycle
//   advance      : a grant was taken; move priority past the grantee
//   grant        : one-hot grant (zero when nothing is eligible)
//   grant_idx    : binary index of the grantee
// Priority starts at ptr, the requester after the last grantee; reset
// puts ptr on requester 0.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [NREQ-1:0] eligible,
   input  logic            advance,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx
);

   logic [IDW-1:0] ptr;
   logic           found;

   // Two passes give the wrapped search order ptr..NREQ-1, then 0..ptr-1.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         if (!found && eligible[j] && (j >= int'(ptr))) begin
            grant[j]  = 1'b1;
            grant_idx = IDW'(j);
            found     = 1'b1;
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!found && eligible[j] && (j < int'(ptr))) begin
            grant[j]  = 1'b1;
            grant_idx = IDW'(j);
            found     = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset)
         ptr <= '0;
      else if (advance)
         ptr <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDW'(1);
   end

endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter -- shares one LIFO between NREQ requesters.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   bus (slave)         : request/grant handshake and pop responses
//   flush / flush_done  : flush request, one-cycle completion pulse
//   lifo_reset/push/pop : LIFO controls; lifo_data is the push word
//   lifo_q              : LIFO read word, holding the popped value in the
//                         cycle after lifo_pop
//   lifo_empty/full     : registered LIFO status flags
//   occupancy/high_water: only with STACK_ARBITER_OCCUPANCY_EN defined;
//                         shadow fill count and its maximum since reset
// At most one stack operation is issued per cycle. Pop responses come out
// the cycle after the grant; a pop on an empty stack answers resp_err=1.
module stack_arbiter
   import stack_arbiter_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int DEPTH = DEF_DEPTH,
   parameter int DW    = DEF_DW,
   parameter int IDW   = 1
) (
   input  logic          clock,
   input  logic          reset,
   stack_arbiter_if.slave bus,
   input  logic          flush,
   output logic          flush_done,
   output logic          lifo_reset,
   output logic          lifo_push,
   output logic          lifo_pop,
   output logic [DW-1:0] lifo_data,
   input  logic [DW-1:0] lifo_q,
   input  logic          lifo_empty,
   input  logic          lifo_full
`ifdef STACK_ARBITER_OCCUPANCY_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic [$clog2(DEPTH+1)-1:0] high_water
`endif
);

   state_t                   state, state_nx;
   logic                     run_ok;
   logic                     push_ok;
   logic [NREQ-1:0]          eligible;
   logic [NREQ-1:0]          grant;
   logic [IDW-1:0]           gidx;
   logic                     any_grant;
   logic                     g_op;
   logic                     pop_grant;
   logic [NREQ-1:0][DW-1:0]  req_data_a;
   logic                     rv_q, rerr_q;
   logic [IDW-1:0]           rid_q;
   logic                     resp_v;

   // ---------------- flush sequencer ----------------
   always_ff @(posedge clock) begin
      if (reset) state <= RUN;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      run_ok     = 1'b0;
      flush_done = 1'b0;
      lifo_reset = reset;
      case (state)
         RUN: begin
            // flush wins over every request in the cycle it is seen
            if (flush) state_nx = FLUSH;
            else       run_ok   = !reset;
         end
         FLUSH: begin
            state_nx   = DRAIN;
            lifo_reset = 1'b1;
         end
         DRAIN: begin
            // LIFO flags settle from the reset during this cycle
            state_nx   = RUN;
            flush_done = !reset;
         end
         default: state_nx = RUN;
      endcase
   end

   // ---------------- push eligibility ----------------
`ifdef STACK_ARBITER_OCCUPANCY_EN
   localparam int OW = $clog2(DEPTH + 1);
   logic [OW-1:0] occ_nx;
   logic          unused_full;

   // The shadow count is exact at every edge, so the lagging full flag
   // is not needed and pushes may issue back to back.
   assign unused_full = lifo_full;
   assign push_ok     = (occupancy < OW'(DEPTH));

   always_comb begin
      occ_nx = occupancy;
      if (state == FLUSH)  occ_nx = '0;
      else if (lifo_push)  occ_nx = occupancy + OW'(1);
      else if (lifo_pop)   occ_nx = occupancy - OW'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         occupancy  <= '0;
         high_water <= '0;
      end else begin
         occupancy <= occ_nx;
         if (occ_nx > high_water) high_water <= occ_nx;
      end
   end
`else
   logic last_push;

   // lifo_full does not yet reflect a push issued last cycle
   always_ff @(posedge clock) begin
      if (reset) last_push <= 1'b0;
      else       last_push <= lifo_push;
   end

   assign push_ok = !lifo_full && !last_push;
`endif

   // ---------------- arbitration ----------------
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NREQ; i++)
         eligible[i] = run_ok && bus.req_valid[i] &&
                       ((bus.req_op[i] == OP_POP) || push_ok);
   end

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
      .clock     (clock),
      .reset     (reset),
      .eligible  (eligible),
      .advance   (any_grant),
      .grant     (grant),
      .grant_idx (gidx)
   );

   assign bus.req_ready = grant;
   assign any_grant     = |grant;
   assign g_op          = bus.req_op[gidx];
   assign pop_grant     = any_grant && (g_op == OP_POP);
   assign req_data_a    = bus.req_data;

   // ---------------- issue ----------------
   assign lifo_push = any_grant && (g_op == OP_PUSH);
   assign lifo_pop  = pop_grant && !lifo_empty;
   assign lifo_data = lifo_push ? req_data_a[gidx] : '0;

   // ---------------- pop response ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         rv_q   <= 1'b0;
         rid_q  <= '0;
         rerr_q <= 1'b0;
      end else begin
         rv_q   <= pop_grant;
         rid_q  <= pop_grant ? gidx : '0;
         rerr_q <= pop_grant && lifo_empty;
      end
   end

   // Gating with reset drops a response still in flight when reset hits.
   assign resp_v         = rv_q && !reset;
   assign bus.resp_valid = resp_v;
   assign bus.resp_id    = resp_v ? rid_q : '0;
   assign bus.resp_err   = resp_v && rerr_q;
   assign bus.resp_data  = (resp_v && !rerr_q) ? lifo_q : '0;

endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter -- self-checking bench for stack_arbiter.
// A behavioural LIFO is attached to the DUT. A reference model (plain
// queue stack, round-robin pointer, flush countdown) predicts each grant
// and queues the expected pop response; a monitor compares every cycle.
// Build with STACK_ARBITER_OCCUPANCY_EN to include the occupancy test.
module tb_stack_arbiter;
   import stack_arbiter_pkg::*;

   localparam int NREQ  = 2;
   localparam int DEPTH = 16;
   localparam int DW    = 16;
   localparam int IDW   = 1;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [DW-1:0]  data;
      logic           err;
      logic           skip_err;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic          flush_done, lifo_reset, lifo_push, lifo_pop;
   logic [DW-1:0] lifo_data;
   logic [DW-1:0] lifo_q = '0;
   logic          lifo_empty = 1'b1;
   logic          lifo_full  = 1'b0;
`ifdef STACK_ARBITER_OCCUPANCY_EN
   logic [4:0]    occupancy, high_water;
`endif

   always #5 clock = ~clock;

   stack_arbiter_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) bus ();

   stack_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .DW(DW), .IDW(IDW)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus),
      .flush      (flush),
      .flush_done (flush_done),
      .lifo_reset (lifo_reset),
      .lifo_push  (lifo_push),
      .lifo_pop   (lifo_pop),
      .lifo_data  (lifo_data),
      .lifo_q     (lifo_q),
      .lifo_empty (lifo_empty),
      .lifo_full  (lifo_full)
`ifdef STACK_ARBITER_OCCUPANCY_EN
      ,
      .occupancy  (occupancy),
      .high_water (high_water)
`endif
   );

   // ---------------- behavioural LIFO ----------------
   logic [DW-1:0] mem [DEPTH];
   int            cnt = 0;

   always @(posedge clock) begin
      if (lifo_reset) begin
         cnt        <= 0;
         lifo_empty <= 1'b1;
         lifo_full  <= 1'b0;
      end else if (lifo_push && cnt < DEPTH) begin
         mem[cnt]   <= lifo_data;
         cnt        <= cnt + 1;
         lifo_empty <= 1'b0;
         lifo_full  <= (cnt + 1 == DEPTH);
      end else if (lifo_pop && cnt > 0) begin
         lifo_q     <= mem[cnt-1];
         cnt        <= cnt - 1;
         lifo_empty <= (cnt == 1);
         lifo_full  <= 1'b0;
      end
   end

   // ---------------- reference model state ----------------
   int              total = 0;
   int              bad   = 0;
   logic [DW-1:0]   m_stack[$];
   exp_t            expq[$];
   exp_t            e;
   int              rr_next = 0;
   int              busy = 0;
   int              m_hw = 0;
   int              m_idx;
   int              gi;
   logic            pend = 1'b0;
   logic            prev_push = 1'b0;
   logic            push_ok_m;
   logic [NREQ-1:0] eg;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic mon_cycle();
      @(negedge clock);
      if (reset) begin
         chk("rst_req_ready",  32'(bus.req_ready), 0);
         chk("rst_resp_valid", 32'(bus.resp_valid), 0);
         chk("rst_resp_err",   32'(bus.resp_err), 0);
         chk("rst_resp_id",    32'(bus.resp_id), 0);
         chk("rst_resp_data",  32'(bus.resp_data), 0);
         chk("rst_flush_done", 32'(flush_done), 0);
         chk("rst_lifo_push",  32'(lifo_push), 0);
         chk("rst_lifo_pop",   32'(lifo_pop), 0);
         chk("rst_lifo_data",  32'(lifo_data), 0);
         chk("rst_lifo_reset", 32'(lifo_reset), 1);
         m_stack.delete();
         expq.delete();
         rr_next = 0; busy = 0; pend = 1'b0; prev_push = 1'b0; m_hw = 0;
      end else begin
         // response side
         chk("resp_valid", 32'(bus.resp_valid), 32'(pend));
         if (bus.resp_valid && expq.size() != 0) begin
            e = expq.pop_front();
            chk("resp_id",   32'(bus.resp_id), 32'(e.id));
            chk("resp_data", 32'(bus.resp_data), 32'(e.data));
            if (!e.skip_err) chk("resp_err", 32'(bus.resp_err), 32'(e.err));
         end
         pend = 1'b0;
         // grant side
         eg = '0;
         gi = 0;
         if (busy > 0) begin
            chk("flush_lifo_reset", 32'(lifo_reset), 32'(busy == 2));
            chk("flush_done",       32'(flush_done), 32'(busy == 1));
            busy--;
         end else begin
            chk("run_lifo_reset", 32'(lifo_reset), 0);
            chk("run_flush_done", 32'(flush_done), 0);
            if (flush) begin
               m_stack.delete();
               busy = 2;
            end else begin
`ifdef STACK_ARBITER_OCCUPANCY_EN
               push_ok_m = (m_stack.size() < DEPTH);
`else
               push_ok_m = (m_stack.size() < DEPTH) && !prev_push;
`endif
               for (int off = 0; off < NREQ; off++) begin
                  m_idx = (rr_next + off) % NREQ;
                  if (eg == '0 && bus.req_valid[m_idx] &&
                      (bus.req_op[m_idx] == OP_POP || push_ok_m)) begin
                     eg[m_idx] = 1'b1;
                     gi = m_idx;
                  end
               end
            end
         end
         chk("grant", 32'(bus.req_ready), 32'(eg));
         if (eg != '0) begin
            rr_next = (gi + 1) % NREQ;
            if (bus.req_op[gi] == OP_PUSH) begin
               chk("lifo_push", 32'(lifo_push), 1);
               chk("lifo_pop",  32'(lifo_pop), 0);
               chk("lifo_data", 32'(lifo_data), 32'(bus.req_data[gi*DW +: DW]));
               m_stack.push_back(bus.req_data[gi*DW +: DW]);
               if (m_stack.size() > m_hw) m_hw = m_stack.size();
               prev_push = 1'b1;
            end else begin
               e.id       = IDW'(gi);
               e.skip_err = prev_push;  // flag may be stale right after a push
               if (m_stack.size() == 0) begin
                  e.err  = 1'b1;
                  e.data = '0;
                  chk("lifo_pop_empty", 32'(lifo_pop), 0);
               end else begin
                  e.err  = 1'b0;
                  e.data = m_stack.pop_back();
                  chk("lifo_pop", 32'(lifo_pop), 1);
               end
               chk("lifo_push_on_pop", 32'(lifo_push), 0);
               expq.push_back(e);
               pend      = 1'b1;
               prev_push = 1'b0;
            end
         end else begin
            chk("idle_lifo_push", 32'(lifo_push), 0);
            chk("idle_lifo_pop",  32'(lifo_pop), 0);
            prev_push = 1'b0;
         end
      end
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Hold a request until the grant edge; the grant is bounded by a budget.
   task automatic issue(int i, logic op, logic [DW-1:0] d);
      int   n;
      logic got;
      n   = 0;
      got = 1'b0;
      bus.req_valid[i]          = 1'b1;
      bus.req_op[i]             = op;
      bus.req_data[i*DW +: DW]  = d;
      while (!got && n < 100) begin
         @(negedge clock);
         got = bus.req_ready[i];
         @(posedge clock);
         #1;
         n++;
      end
      bus.req_valid[i] = 1'b0;
      chk("handshake", 32'(got), 1);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      idle(1);
      flush = 1'b0;
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_op    = '0;
      bus.req_data  = '0;
      fork
         forever mon_cycle();
      join_none

      // 1: reset, then push / idle / pop across requesters
      repeat (4) @(posedge clock);
      #1 reset = 1'b0;
      issue(0, OP_PUSH, 16'h1234);
      idle(1);
      issue(1, OP_POP, '0);
      idle(2);

      // 2: both requesters popping an empty stack
      bus.req_op    = '1;
      bus.req_valid = '1;
      idle(8);
      bus.req_valid = '0;
      idle(2);

      // 3: fill to full, blocked 17th push, drain in LIFO order
      for (int k = 0; k < DEPTH; k++) begin
         issue(0, OP_PUSH, DW'(k));
         idle(1);
      end
      bus.req_op[0]        = OP_PUSH;
      bus.req_data[0 +: DW] = 16'h0010;
      bus.req_valid[0]     = 1'b1;
      idle(4);
      bus.req_valid[0]     = 1'b0;
      for (int k = 0; k < DEPTH; k++) issue(1, OP_POP, '0);
      idle(2);

      // 4: flush with data on the stack, then pop the emptied stack
      issue(0, OP_PUSH, 16'hAAAA);
      idle(1);
      issue(1, OP_PUSH, 16'hBBBB);
      idle(1);
      do_flush();
      idle(3);
      issue(0, OP_POP, '0);
      idle(2);

      // 5: pop granted the cycle before flush
      issue(0, OP_PUSH, 16'h5A5A);
      idle(1);
      issue(1, OP_POP, '0);
      do_flush();
      idle(3);

      // random traffic with occasional flushes
      repeat (500) begin
         for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]         = ($urandom_range(0, 3) != 0);
            bus.req_op[i]            = ($urandom_range(0, 2) == 0);
            bus.req_data[i*DW +: DW] = DW'($urandom);
         end
         flush = ($urandom_range(0, 39) == 0);
         idle(1);
      end
      bus.req_valid = '0;
      flush         = 1'b0;
      idle(3);

`ifdef STACK_ARBITER_OCCUPANCY_EN
      // 6: back-to-back pushes, occupancy and high-water tracking
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) issue(0, OP_PUSH, DW'(16'h100 + k));
      issue(1, OP_POP, '0);
      issue(1, OP_POP, '0);
      idle(2);
      chk("occupancy",  32'(occupancy), 32'(m_stack.size()));
      chk("high_water", 32'(high_water), 32'(m_hw));
      do_flush();
      idle(3);
      chk("occupancy_flushed",  32'(occupancy), 32'(m_stack.size()));
      chk("high_water_flushed", 32'(high_water), 32'(m_hw));
`endif

      chk("scoreboard_drained", 32'(expq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
